// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
//   rx_state_t       receiver FSM encoding
//   UART_DATA_BITS   default data bits per frame
//   UART_OVERSAMPLE  default div_clk cycles per bit
//   even_parity()    parity bit that makes the total count of ones even
package uart_pkg;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  // Callers zero-extend their data word; extra zeros do not change the XOR.
  function automatic logic even_parity(input logic [31:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Host-side byte handshake of the UART receiver.
//   rx_data   received byte, stable while rx_valid=1
//   rx_valid  holding register contains an unconsumed byte
//   rx_ready  consumer takes rx_data this cycle
// master = receiver side, slave = consumer side.
interface uart_rx_if
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = UART_DATA_BITS
);

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous level; resets to 1 (idle line).
//   clk, rst_n  clock and asynchronous active-low reset
//   d           asynchronous input
//   q           synchronised output
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversamples rx_serial on div_clk, validates the start
// bit at its centre, samples each data bit at its centre, checks the stop
// bit and hands good bytes to a single holding register (valid/ready).
//   div_clk     OVERSAMPLE x baud clock
//   rst_n       asynchronous active-low reset
//   rx_serial   asynchronous serial line, idle high
//   bus         uart_rx_if.master: rx_data / rx_valid / rx_ready
//   frame_err   one-cycle pulse, stop bit sampled 0
//   overrun     one-cycle pulse, good byte dropped (holding register full)
//   parity_err  one-cycle pulse, even-parity mismatch
//   busy        FSM not in IDLE
// Optional: define UART_RX_PARITY_EN to insert an even-parity bit between
// the data and the stop bit; otherwise parity_err stays 0.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
  parameter int unsigned DATA_BITS  = UART_DATA_BITS
) (
  input  logic      div_clk,
  input  logic      rst_n,
  input  logic      rx_serial,
  uart_rx_if.master bus,
  output logic      frame_err,
  output logic      overrun,
  output logic      parity_err,
  output logic      busy
);

  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  // Input path
  logic       rx_s;
  logic       rx_s_d;
  logic [1:0] warm_q;
  logic       fall_c;

  // FSM and datapath
  rx_state_t            state_q, state_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 good_q, good_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
`endif

  sync_2ff u_sync (
    .clk   (div_clk),
    .rst_n (rst_n),
    .d     (rx_serial),
    .q     (rx_s)
  );

  // Edge-detect flop plus a warm-up count: the synchroniser's reset value of 1
  // must not pair with a line that is already low at reset release.
  always_ff @(posedge div_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s_d <= 1'b1;
      warm_q <= 2'd0;
    end else begin
      rx_s_d <= rx_s;
      if (warm_q != 2'd3) begin
        warm_q <= warm_q + 2'd1;
      end
    end
  end

  assign fall_c = (warm_q == 2'd3) && rx_s_d && !rx_s;

  // State and datapath registers
  always_ff @(posedge div_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      good_q  <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      good_q  <= good_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state and frame-completion decode
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    good_d  = 1'b0;
    ferr_d  = 1'b0;
    perr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (fall_c) begin
          state_d = START;
          tick_d  = '0;
        end
      end

      START: begin
        if (tick_q == TICK_MID) begin
          tick_d = '0;
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            bit_d   = '0;
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end

      // Shift right so LSB-first data ends up in natural bit order.
      DATA: begin
        if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          par_d   = rx_s;
          state_d = STOP;
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
`endif

      // Return to IDLE at mid-stop so a following start edge is not missed.
      STOP: begin
        if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          state_d = IDLE;
          if (!rx_s) begin
            ferr_d = 1'b1;
          end
`ifdef UART_RX_PARITY_EN
          else if (par_q != even_parity(32'(shift_q))) begin
            perr_d = 1'b1;
          end
`endif
          else begin
            good_d = 1'b1;
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        tick_d  = '0;
      end
    endcase
  end

  // Holding register, handshake and status pulses
  always_ff @(posedge div_clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rx_data  <= '0;
      bus.rx_valid <= 1'b0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
      parity_err   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      frame_err  <= ferr_q;
      parity_err <= perr_q;
      overrun    <= 1'b0;
      busy       <= (state_d != IDLE);
      if (good_q) begin
        // A byte consumed in the same cycle frees the slot for the new one.
        if (!bus.rx_valid || bus.rx_ready) begin
          bus.rx_data  <= shift_q;
          bus.rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (bus.rx_valid && bus.rx_ready) begin
        bus.rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned OS = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
  localparam int LAT   = 172;
`else
  localparam int NBITS = 10;
  localparam int LAT   = 156;
`endif

  logic div_clk = 1'b0;
  logic rst_n;
  logic rx_serial;
  logic frame_err, overrun, parity_err, busy;

  uart_rx_if #(.DATA_BITS(8)) bus ();

  uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
    .div_clk    (div_clk),
    .rst_n      (rst_n),
    .rx_serial  (rx_serial),
    .bus        (bus.master),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 div_clk = ~div_clk;

  int cyc = 0;
  always @(posedge div_clk) cyc <= cyc + 1;

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard and pulse monitor
  logic [7:0] exp_q[$];
  int n_rise = 0, n_ferr = 0, n_ovr = 0, n_perr = 0;
  int rise_cyc = 0, ferr_cyc = 0, ovr_cyc = 0;
  logic prev_valid = 1'b0;

  always @(negedge div_clk) begin
    if (bus.rx_valid && !prev_valid) begin n_rise++; rise_cyc = cyc; end
    if (frame_err)  begin n_ferr++; ferr_cyc = cyc; end
    if (overrun)    begin n_ovr++;  ovr_cyc  = cyc; end
    if (parity_err) n_perr++;
    if (rst_n && bus.rx_valid && bus.rx_ready) begin
      if (exp_q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_byte: got 0x%0h with nothing expected", bus.rx_data);
      end else begin
        check("sb_rx_data", 32'(bus.rx_data), 32'(exp_q.pop_front()));
      end
    end
    prev_valid = bus.rx_valid;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge div_clk);
      #1;
    end
  endtask

  function automatic logic [15:0] build(input logic [7:0] d, input logic stop, input logic par);
    logic [15:0] v;
    v = '1;
    v[0] = 1'b0;
    v[8:1] = d;
    v[9] = par;
    v[NBITS-1] = stop;
    return v;
  endfunction

  task automatic send_bits(input logic [15:0] v, input int n, output int t0);
    t0 = cyc;
    for (int b = 0; b < n; b++) begin
      rx_serial = v[b];
      step(OS);
    end
    rx_serial = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par, output int t0);
    send_bits(build(d, stop, par), NBITS, t0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_ferr;
  } tv_t;

  tv_t tv[8];

  initial begin
    int t0, t1, r0, f0, o0, p0;
    logic [15:0] v;

    tv[0] = '{8'hA5, 1'b1, 1'b0};
    tv[1] = '{8'h3C, 1'b0, 1'b1};
    tv[2] = '{8'h11, 1'b1, 1'b0};
    tv[3] = '{8'h00, 1'b1, 1'b0};
    tv[4] = '{8'hFF, 1'b1, 1'b0};
    tv[5] = '{8'h80, 1'b1, 1'b0};
    tv[6] = '{8'h01, 1'b1, 1'b0};
    tv[7] = '{8'h3C, 1'b0, 1'b1};

    rst_n = 1'b0;
    rx_serial = 1'b1;
    bus.rx_ready = 1'b0;
    step(3);
    check("rst_rx_data", 32'(bus.rx_data), 0);
    check("rst_rx_valid", 32'(bus.rx_valid), 0);
    check("rst_flags", {29'd0, frame_err, overrun, parity_err}, 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    step(5);

    // Table: single frames with the consumer always ready
    for (int i = 0; i < 8; i++) begin
      r0 = n_rise; f0 = n_ferr; o0 = n_ovr;
      bus.rx_ready = 1'b1;
      if (tv[i].stop) exp_q.push_back(tv[i].data);
      send_frame(tv[i].data, tv[i].stop, ^tv[i].data, t0);
      step(4);
      check("tbl_ferr_cnt", 32'(n_ferr - f0), 32'(tv[i].exp_ferr));
      check("tbl_ovr_cnt", 32'(n_ovr - o0), 0);
      check("tbl_valid_cnt", 32'(n_rise - r0), 32'(!tv[i].exp_ferr));
      if (tv[i].exp_ferr) check("tbl_ferr_lat", 32'(ferr_cyc), 32'(t0 + LAT));
      else                check("tbl_valid_lat", 32'(rise_cyc), 32'(t0 + LAT));
      check("tbl_valid_idle", 32'(bus.rx_valid), 0);
    end

    // Short glitch: false start, nothing reported
    r0 = n_rise; f0 = n_ferr;
    t0 = cyc;
    rx_serial = 1'b0;
    step(3);
    rx_serial = 1'b1;
    step(5);
    check("glitch_busy_hi", 32'(busy), 1);
    step(20);
    check("glitch_busy_lo", 32'(busy), 0);
    check("glitch_valid_cnt", 32'(n_rise - r0), 0);
    check("glitch_ferr_cnt", 32'(n_ferr - f0), 0);

    // Reset in the middle of data bit 4 of 0x55
    r0 = n_rise;
    v = build(8'h55, 1'b1, ^8'h55);
    send_bits(v, 5, t0);
    rx_serial = v[5];
    step(8);
    check("mid_busy", 32'(busy), 1);
    check("mid_data_before", 32'(bus.rx_data), 32'h01);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_data", 32'(bus.rx_data), 0);
    check("mid_rst_valid", 32'(bus.rx_valid), 0);
    step(2);
    rst_n = 1'b1;
    step(200);
    check("mid_after_busy", 32'(busy), 0);
    check("mid_after_valid_cnt", 32'(n_rise - r0), 0);
    exp_q.push_back(8'h96);
    send_frame(8'h96, 1'b1, ^8'h96, t0);
    step(4);
    check("post_rst_valid_cnt", 32'(n_rise - r0), 1);
    check("post_rst_lat", 32'(rise_cyc), 32'(t0 + LAT));

    // Line already low at reset release is not a start
    rst_n = 1'b0;
    rx_serial = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(40);
    check("low_release_busy", 32'(busy), 0);
    rx_serial = 1'b1;
    step(40);
    check("low_release_busy2", 32'(busy), 0);
    exp_q.push_back(8'hC3);
    r0 = n_rise;
    send_frame(8'hC3, 1'b1, ^8'hC3, t0);
    step(4);
    check("low_release_frame", 32'(n_rise - r0), 1);

    // Back-to-back frames with consumer stalled: second one overruns
    bus.rx_ready = 1'b0;
    o0 = n_ovr; f0 = n_ferr;
    exp_q.push_back(8'h00);
    send_frame(8'h00, 1'b1, 1'b0, t0);
    send_frame(8'hFF, 1'b1, ^8'hFF, t1);
    step(4);
    check("ovr_cnt", 32'(n_ovr - o0), 1);
    check("ovr_lat", 32'(ovr_cyc), 32'(t1 + LAT));
    check("ovr_ferr_cnt", 32'(n_ferr - f0), 0);
    check("ovr_data_kept", 32'(bus.rx_data), 32'h00);
    check("ovr_valid_held", 32'(bus.rx_valid), 1);
    bus.rx_ready = 1'b1;
    step(1);
    check("ovr_valid_drop", 32'(bus.rx_valid), 0);

`ifdef UART_RX_PARITY_EN
    r0 = n_rise; p0 = n_perr;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1, t0);
    step(4);
    check("par_ok_valid_cnt", 32'(n_rise - r0), 1);
    check("par_ok_perr_cnt", 32'(n_perr - p0), 0);
    send_frame(8'h07, 1'b1, 1'b0, t0);
    step(4);
    check("par_bad_perr_cnt", 32'(n_perr - p0), 1);
    check("par_bad_valid_cnt", 32'(n_rise - r0), 1);
`else
    p0 = 0;
    check("perr_never", 32'(n_perr - p0), 0);
`endif

    step(4);
    check("sb_queue_empty", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver that pairs with the UART transmit shift register: 8N1 framing, LSB first, idle-high line.
- Oversamples `rx_serial` on the divided clock, validates the start bit, samples each bit at its centre and checks the stop bit.
- Delivers bytes to the host side through a single holding register with a valid/ready handshake.

Parameters:
- OVERSAMPLE, 16, div_clk cycles per bit; must be even and ≥4.
- DATA_BITS, 8, data bits per frame.

Ports:
- div_clk  input  1  oversampling clock, OVERSAMPLE × baud rate.
- rst_n  input  1  asynchronous active-low reset.
- rx_serial  input  1  asynchronous serial line, idle high.
- rx_ready  input  1  consumer accepts rx_data this cycle.
- rx_data  output  DATA_BITS  received byte, held stable while rx_valid=1.
- rx_valid  output  1  rx_data holds an unconsumed byte.
- frame_err  output  1  one-cycle pulse: stop bit sampled 0.
- overrun  output  1  one-cycle pulse: good frame dropped because holding register full.
- parity_err  output  1  one-cycle pulse: parity mismatch (only with UART_RX_PARITY_EN, else tied 0).
- busy  output  1  FSM not in IDLE.

Behaviour:
- Clock is div_clk; reset is asynchronous, active-low on rst_n.
- Reset values:
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0, parity_err=0, busy=0.
  - Synchroniser flops = 1, FSM=IDLE, counters=0.
- Input path: 2-flop synchroniser on rx_serial, giving rx_s; a third flop holds rx_s_d for edge detection.
- Counters:
  - tick_cnt, width $clog2(OVERSAMPLE), counts div_clk cycles within a bit.
  - bit_cnt, width $clog2(DATA_BITS+1), counts data bits.
  - Shift register fills from the MSB (shift right, new bit into bit DATA_BITS-1), so LSB-first data lands in order.
- FSM states IDLE, START, DATA, (PARITY), STOP.
  - IDLE: on rx_s_d=1 and rx_s=0 (falling edge, cycle E), go to START with tick_cnt=0.
  - START: at tick_cnt=OVERSAMPLE/2-1 (cycle E+7), sample rx_s.
    - If 1: false start, return to IDLE with no flag.
    - If 0: go to DATA, tick_cnt=0, bit_cnt=0.
  - DATA: at tick_cnt=OVERSAMPLE-1, shift in rx_s and increment bit_cnt. After DATA_BITS samples, go to STOP (or PARITY).
    - Data bit i is sampled at cycle E+7+16(i+1).
  - STOP: at tick_cnt=OVERSAMPLE-1 (cycle E+151), sample rx_s and go to IDLE immediately (mid-stop). This allows back-to-back frames with zero extra idle.
    - Stop=1: frame good.
    - Stop=0: frame_err pulse next cycle; byte discarded; rx_valid/rx_data unchanged.
- Delivery of a good frame (registered on the cycle after the stop sample, E+152):
  - rx_valid=0: load rx_data, rx_valid←1.
  - rx_valid=1 and rx_ready=1 in the same cycle: load new byte; rx_valid stays 1.
  - rx_valid=1 and rx_ready=0: overrun pulse; new byte dropped; old byte retained.
- Consumption: rx_valid=1 and rx_ready=1 with no completion clears rx_valid the next cycle. rx_ready while rx_valid=0 has no effect.
- Framing errors have priority over overrun: a bad-stop frame never raises overrun.
- busy=1 in every state except IDLE.
- Reset asserted mid-frame: everything returns to reset values immediately. A line low at reset release is not treated as a start until a 1→0 edge is seen.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - PARITY state is inserted between DATA and STOP, sampled at tick OVERSAMPLE-1.
  - Even parity is checked over the data bits.
  - On mismatch, parity_err pulses in the delivery cycle and the byte is discarded (no rx_valid, no overrun).
  - Stop sample shifts to E+167.
- Undefined: no PARITY state; parity_err tied 0.

Decomposition:
- Package uart_pkg:
  - typedef enum logic [2:0] rx_state_t {IDLE, START, DATA, PARITY, STOP}.
  - Localparams UART_DATA_BITS=8, UART_OVERSAMPLE=16.
  - Function even_parity().
- Natural sub-module: sync_2ff (2-flop synchroniser, reset value 1). The FSM, counters and holding register stay in uart_rx.

Test Plan:
- Single frame 0xA5, 16 cycles/bit, rx_ready=1 → rx_valid high at E+152, rx_data=0xA5, one cycle, no error flags.
- Glitch low for 3 cycles then high → FSM returns to IDLE at E+7; no flags; rx_valid stays 0.
- Frame 0x3C with stop bit driven 0 → frame_err pulse at E+152; rx_valid stays 0; next good frame 0x11 is received correctly.
- Two back-to-back frames 0x00, 0xFF, rx_ready=0 → first: rx_valid=1, data 0x00; second: overrun pulse, data still 0x00. Raise rx_ready → rx_valid drops next cycle.
- rst_n pulsed low at data bit 4 of 0x55, then frame 0x96 → all outputs at reset values; 0x96 received intact.
- UART_RX_PARITY_EN defined:
  - 0x07 with parity bit 1 → rx_data=0x07, valid.
  - 0x07 with parity bit 0 → parity_err pulse, no valid.
